button_event_encoder: RTL and testbench
=======================================

Name: button_event_encoder

Overview:
Receive-side companion to the PMOD button stimulus: samples four raw button pins, synchronises and debounces them, and encodes press / release / long-press transitions into a small event FIFO. The FIFO is drained over a valid/ready handshake. Debounced levels are mirrored on the four board LEDs. Sits between the PMOD header pins and any downstream consumer (UART reporter, menu FSM).

Parameters:
DEBOUNCE_CYCLES, 12000, consecutive mismatching cycles before the debounced level flips (1 ms at 12 MHz); must be >= 2
LONG_CYCLES, 6000000, cycles a debounced press must persist to emit one long-press event (0.5 s at 12 MHz)
FIFO_DEPTH, 4, event FIFO entries; power of two, >= 2

Ports:
CLK  in  1  system clock, 12 MHz
RST  in  1  reset, asynchronous, active-high
P1A7  in  1  raw button 0, active-high, asynchronous to CLK
P1A8  in  1  raw button 1
P1A9  in  1  raw button 2
P1A10  in  1  raw button 3
EVT_READY  in  1  consumer accepts head event
OVF_CLR  in  1  one-cycle pulse, clears OVERFLOW
EVT_VALID  out  1  FIFO non-empty
EVT_BTN  out  2  button index of head event, 0..3
EVT_KIND  out  2  00 press, 01 release, 10 long-press, 11 never emitted
OVERFLOW  out  1  sticky: an event was dropped
LED1..LED4  out  1 each  debounced level of buttons 0..3

Behaviour:
- Reset (async assert, sync release): synchronisers, debounced levels, counters, pending slots, FIFO pointers/count cleared. All outputs 0: LEDs, EVT_VALID, EVT_BTN, EVT_KIND, OVERFLOW.
- Synchroniser: two flops per pin. Pin level first sampled at edge k appears on sync2 after edge k+1.
- Debounce, per channel: at each edge where sync2 != stable:
  - if cnt == DEBOUNCE_CYCLES-1: stable <= sync2, cnt <= 0;
  - else cnt++.
  - Any edge with sync2 == stable: cnt <= 0.
  - Net: a clean level change first sampled at edge k flips stable at edge k+DEBOUNCE_CYCLES+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never flips stable.
- LEDn = stable[n-1], registered, no extra latency.
- Event detection, per channel:
  - stable 0->1 raises press; stable 1->0 raises release.
  - Long counter clears on the press and counts while stable==1. When it reaches LONG_CYCLES-1, raise long-press once; the counter then saturates, no repeat until the next press.
  - A release before that point emits no long-press.
- Pending slot: one per channel (valid bit + 2-bit kind).
  - New event while the slot is empty: stored.
  - New event while the slot is occupied: dropped, OVERFLOW <= 1.
  - This preserves per-channel ordering.
- Arbiter: each cycle with FIFO count < FIFO_DEPTH, the lowest-index channel with an occupied slot is written {btn, kind} and its slot freed that same edge. At most one enqueue per cycle.
  - Enqueue uses count before the edge; when full, no enqueue even if a dequeue occurs the same cycle.
  - A slot freed at edge e may accept a new event detected at edge e.
- FIFO: first-word fall-through. EVT_VALID = (count != 0); EVT_BTN/EVT_KIND show the head entry.
  - Dequeue on an edge with EVT_VALID && EVT_READY.
  - Simultaneous enqueue+dequeue: count unchanged. Pointers wrap modulo FIFO_DEPTH.
  - Head fields hold stable while EVT_VALID && !EVT_READY.
- OVERFLOW: set on any drop; OVF_CLR clears it. Set and clear in the same cycle: set wins.
- EVT_READY while EVT_VALID==0: ignored.
- Reset mid-operation: all queued and pending events discarded.
  - A pin held high across reset release produces a press event DEBOUNCE_CYCLES+1 edges after the first sampling edge, because stable resets to 0.

Test Plan:
Use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, FIFO_DEPTH=4 for all cases.
- Clean press: P1A7 0->1 before edge 10, EVT_READY=1 -> LED1 rises after edge 15; EVT_VALID=1 for one cycle after edge 16 with EVT_BTN=0, EVT_KIND=00.
- Glitch rejection: P1A8 high for 3 cycles -> LED2 stays 0; no event; OVERFLOW=0.
- Long press: P1A9 held 40 cycles, then released, EVT_READY=1 -> events in order (2,00), (2,10), (2,01); exactly one long-press.
- Simultaneous press: all four pins rise on the same cycle -> four presses dequeued on consecutive cycles in order btn 0,1,2,3.
- Backpressure/overflow: EVT_READY=0; press+release on btn0, then btn1, then btn2 (6 events) -> EVT_VALID=1 with head (0,00) held stable; FIFO holds 4 entries; btn2 press pending; btn2 release dropped; OVERFLOW=1.
  - Then OVF_CLR pulse with EVT_READY=1 -> OVERFLOW=0; 5 events drain.
- Reset mid-stream: assert RST while FIFO holds 2 events and P1A10 is high -> all outputs 0 immediately.
  - After release: one press (3,00) appears DEBOUNCE_CYCLES+2 cycles later; no stale events.

Source files
------------

// File: rtl/button_event_encoder.sv
// Four-button receive front end: two-flop sync, per-channel debounce, press/release/long-press
// event encoding into per-channel pending slots, fixed-priority arbiter and a FWFT event FIFO.
module button_event_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 12000,
  parameter int unsigned LONG_CYCLES     = 6000000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       P1A7,
  input  logic       P1A8,
  input  logic       P1A9,
  input  logic       P1A10,
  input  logic       EVT_READY,
  input  logic       OVF_CLR,
  output logic       EVT_VALID,
  output logic [1:0] EVT_BTN,
  output logic [1:0] EVT_KIND,
  output logic       OVERFLOW,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4
);

  localparam int unsigned NCH = 4;
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned LW  = $clog2(LONG_CYCLES + 1);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] KIND_PRESS   = 2'b00;
  localparam logic [1:0] KIND_RELEASE = 2'b01;
  localparam logic [1:0] KIND_LONG    = 2'b10;

  typedef struct packed {
    logic [1:0] btn;
    logic [1:0] kind;
  } evt_t;

  logic [NCH-1:0] pins;
  logic [NCH-1:0] sync1_q, sync2_q;
  logic [NCH-1:0] stable_q, stable_d;
  logic [DBW-1:0] db_cnt_q [NCH];
  logic [DBW-1:0] db_cnt_d [NCH];
  logic [LW-1:0]  long_cnt_q [NCH];
  logic [LW-1:0]  long_cnt_d [NCH];
  logic [NCH-1:0] ev_v;
  logic [1:0]     ev_kind [NCH];
  logic [NCH-1:0] pend_v_q, pend_v_d;
  logic [1:0]     pend_kind_q [NCH];
  logic [1:0]     pend_kind_d [NCH];
  logic [NCH-1:0] grant;
  logic           enq, deq, drop;
  evt_t           enq_evt;
  evt_t           mem_q [FIFO_DEPTH];
  evt_t           mem_d [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  evt_t           head_q, head_d;
  logic           valid_q, valid_d;
  logic           ovf_q, ovf_d;

  assign pins = {P1A10, P1A9, P1A8, P1A7};

  // Per-channel debounce and event detection
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      stable_d[i]   = stable_q[i];
      db_cnt_d[i]   = '0;
      long_cnt_d[i] = long_cnt_q[i];
      ev_v[i]       = 1'b0;
      ev_kind[i]    = KIND_PRESS;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
        end
      end
      if (stable_d[i] && !stable_q[i]) begin
        ev_v[i]       = 1'b1;
        ev_kind[i]    = KIND_PRESS;
        long_cnt_d[i] = '0;
      end else if (!stable_d[i] && stable_q[i]) begin
        ev_v[i]    = 1'b1;
        ev_kind[i] = KIND_RELEASE;
      end else if (stable_d[i] && long_cnt_q[i] != LW'(LONG_CYCLES - 1)) begin
        // Saturates at the terminal value so long-press fires once per press
        long_cnt_d[i] = long_cnt_q[i] + LW'(1);
        if (long_cnt_d[i] == LW'(LONG_CYCLES - 1)) begin
          ev_v[i]    = 1'b1;
          ev_kind[i] = KIND_LONG;
        end
      end
    end
  end

  // Arbiter, pending slots, FIFO and overflow flag
  always_comb begin
    grant    = '0;
    enq      = 1'b0;
    enq_evt  = '0;
    drop     = 1'b0;
    mem_d    = mem_q;
    deq      = (count_q != '0) && EVT_READY;
    for (int i = 0; i < NCH; i++) begin
      if (!enq && pend_v_q[i] && (count_q < CW'(FIFO_DEPTH))) begin
        enq          = 1'b1;
        grant[i]     = 1'b1;
        enq_evt.btn  = 2'(i);
        enq_evt.kind = pend_kind_q[i];
      end
    end
    for (int i = 0; i < NCH; i++) begin
      pend_v_d[i]    = pend_v_q[i] && !grant[i];
      pend_kind_d[i] = pend_kind_q[i];
      if (ev_v[i]) begin
        if (pend_v_d[i]) begin
          drop = 1'b1;
        end else begin
          pend_v_d[i]    = 1'b1;
          pend_kind_d[i] = ev_kind[i];
        end
      end
    end
    if (enq) begin
      mem_d[wr_ptr_q] = enq_evt;
    end
    wr_ptr_d = wr_ptr_q + PW'(enq);
    rd_ptr_d = rd_ptr_q + PW'(deq);
    count_d  = count_q + CW'(enq) - CW'(deq);
    head_d   = mem_d[rd_ptr_d];
    valid_d  = (count_d != '0);
    ovf_d    = drop ? 1'b1 : (OVF_CLR ? 1'b0 : ovf_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      pend_v_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        db_cnt_q[i]    <= '0;
        long_cnt_q[i]  <= '0;
        pend_kind_q[i] <= '0;
      end
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        mem_q[j] <= '0;
      end
    end else begin
      sync1_q  <= pins;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      pend_v_q <= pend_v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < NCH; i++) begin
        db_cnt_q[i]    <= db_cnt_d[i];
        long_cnt_q[i]  <= long_cnt_d[i];
        pend_kind_q[i] <= pend_kind_d[i];
      end
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        mem_q[j] <= mem_d[j];
      end
    end
  end

  assign EVT_VALID = valid_q;
  assign EVT_BTN   = head_q.btn;
  assign EVT_KIND  = head_q.kind;
  assign OVERFLOW  = ovf_q;
  assign LED1      = stable_q[0];
  assign LED2      = stable_q[1];
  assign LED3      = stable_q[2];
  assign LED4      = stable_q[3];

endmodule

// File: tb/tb_button_event_encoder.sv
// Bench for button_event_encoder: directed scenarios plus randomized pin/ready traffic,
// all checked each cycle against a behavioural window/queue model of the event encoder.
module tb_button_event_encoder;

  localparam int unsigned DB    = 4;
  localparam int unsigned LC    = 20;
  localparam int unsigned DEPTH = 4;

  logic       clk, rst;
  logic [3:0] pin;
  logic       ready, ovf_clr;
  logic       evt_valid, overflow;
  logic [1:0] evt_btn, evt_kind;
  logic       led1, led2, led3, led4;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  button_event_encoder #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LC),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .P1A7     (pin[0]),
    .P1A8     (pin[1]),
    .P1A9     (pin[2]),
    .P1A10    (pin[3]),
    .EVT_READY(ready),
    .OVF_CLR  (ovf_clr),
    .EVT_VALID(evt_valid),
    .EVT_BTN  (evt_btn),
    .EVT_KIND (evt_kind),
    .OVERFLOW (overflow),
    .LED1     (led1),
    .LED2     (led2),
    .LED3     (led3),
    .LED4     (led4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: pin history window, stable levels, pending slots, event queue
  bit [DB+1:0] m_hist [4];
  bit [3:0]    m_stable;
  int          m_press [4];
  bit          m_slot_v [4];
  bit [1:0]    m_slot_k [4];
  bit [3:0]    m_q [$];
  bit          m_ovf;
  int          m_edge;

  bit [3:0] popped [$];
  int       pop_cyc [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc_no, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_hist[c]   = '0;
      m_press[c]  = 0;
      m_slot_v[c] = 1'b0;
      m_slot_k[c] = 2'b00;
    end
    m_stable = '0;
    m_q.delete();
    m_ovf  = 1'b0;
    m_edge = 0;
  endtask

  task automatic model_step(input bit [3:0] p, input bit r, input bit clr);
    int          pre, g;
    bit          drop, ev;
    bit [1:0]    k;
    bit [DB-1:0] w;
    m_edge++;
    pre = m_q.size();
    g   = -1;
    if (pre < DEPTH)
      for (int c = 0; c < 4; c++) if (g < 0 && m_slot_v[c]) g = c;
    if (pre > 0 && r) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back({2'(g), m_slot_k[g]});
      m_slot_v[g] = 1'b0;
    end
    drop = 1'b0;
    for (int c = 0; c < 4; c++) begin
      m_hist[c] = {m_hist[c][DB:0], p[c]};
      // The debouncer sees the pin two edges late; flip after DB straight disagreeing samples
      w  = m_hist[c][DB+1:2];
      ev = 1'b0;
      k  = 2'b00;
      if (m_stable[c] ? (w == '0) : (&w)) begin
        m_stable[c] = ~m_stable[c];
        ev = 1'b1;
        k  = m_stable[c] ? 2'b00 : 2'b01;
        if (m_stable[c]) m_press[c] = m_edge;
      end else if (m_stable[c] && (m_edge - m_press[c] == LC - 1)) begin
        ev = 1'b1;
        k  = 2'b10;
      end
      if (ev) begin
        if (m_slot_v[c]) drop = 1'b1;
        else begin
          m_slot_v[c] = 1'b1;
          m_slot_k[c] = k;
        end
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic compare();
    check("led", {28'd0, led4, led3, led2, led1}, {28'd0, m_stable});
    check("evt_valid", evt_valid, m_q.size() != 0);
    if (m_q.size() != 0) check("evt_head", {evt_btn, evt_kind}, m_q[0]);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic cyc(input bit [3:0] p, input bit r, input bit clr);
    pin     = p;
    ready   = r;
    ovf_clr = clr;
    cyc_no++;
    if (!rst && evt_valid && r) begin
      popped.push_back({evt_btn, evt_kind});
      pop_cyc.push_back(cyc_no);
    end
    @(posedge clk);
    if (!rst) model_step(p, r, clr);
    @(negedge clk);
    compare();
  endtask

  function automatic logic [31:0] pop_at(input int i);
    if (i < popped.size()) return 32'(popped[i]);
    return 32'hFFFF;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, evt_valid, 1'b0);
    check({tag, "_head"}, {evt_btn, evt_kind}, 4'h0);
    check({tag, "_ovf"}, overflow, 1'b0);
    check({tag, "_leds"}, {led4, led3, led2, led1}, 4'h0);
  endtask

  initial begin
    int          led_at, v_at, v_cnt;
    bit          led_seen;
    bit [3:0]    exp_seq [$];
    int          rem [4];
    bit [3:0]    lvl;
    int          stall;
    bit          r;

    rst = 1'b1; pin = '0; ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) cyc(4'b0000, 1'b1, 1'b0);

    // Clean press: LED after DB+1 edges from first sample, event one edge later
    led_at = -1; v_at = -1; v_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(4'b0001, 1'b1, 1'b0);
      if (led_at < 0 && led1) led_at = i;
      if (evt_valid) begin
        v_cnt++;
        if (v_at < 0) v_at = i;
      end
    end
    check("press_led_lat", led_at, DB + 2);
    check("press_evt_lat", v_at, DB + 3);
    check("press_evt_cycles", v_cnt, 1);
    repeat (12) cyc(4'b0000, 1'b1, 1'b0);

    // Glitch rejection
    popped.delete(); led_seen = 1'b0;
    repeat (3) cyc(4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cyc(4'b0000, 1'b1, 1'b0);
      if (led2) led_seen = 1'b1;
    end
    check("glitch_led", led_seen, 1'b0);
    check("glitch_events", popped.size(), 0);
    check("glitch_ovf", overflow, 1'b0);

    // Long press: press, one long-press, release
    popped.delete();
    repeat (40) cyc(4'b0100, 1'b1, 1'b0);
    repeat (12) cyc(4'b0000, 1'b1, 1'b0);
    check("long_count", popped.size(), 3);
    check("long_ev0", pop_at(0), 4'b1000);
    check("long_ev1", pop_at(1), 4'b1010);
    check("long_ev2", pop_at(2), 4'b1001);

    // Simultaneous press on all four buttons, then release
    popped.delete(); pop_cyc.delete();
    repeat (12) cyc(4'b1111, 1'b1, 1'b0);
    repeat (14) cyc(4'b0000, 1'b1, 1'b0);
    exp_seq = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h1, 4'h5, 4'h9, 4'hD};
    check("simul_count", popped.size(), exp_seq.size());
    foreach (exp_seq[i]) check($sformatf("simul_ev%0d", i), pop_at(i), exp_seq[i]);
    if (pop_cyc.size() >= 4) check("simul_consecutive", pop_cyc[3] - pop_cyc[0], 3);
    else check("simul_consecutive", pop_cyc.size(), 4);

    // Backpressure and overflow
    popped.delete();
    for (int b = 0; b < 3; b++) begin
      repeat (6) cyc(4'(1 << b), 1'b0, 1'b0);
      repeat (6) cyc(4'b0000, 1'b0, 1'b0);
    end
    repeat (8) cyc(4'b0000, 1'b0, 1'b0);
    check("bp_valid", evt_valid, 1'b1);
    check("bp_head", {evt_btn, evt_kind}, 4'h0);
    check("bp_ovf", overflow, 1'b1);
    cyc(4'b0000, 1'b1, 1'b1);
    check("bp_ovf_clr", overflow, 1'b0);
    repeat (10) cyc(4'b0000, 1'b1, 1'b0);
    exp_seq = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h8};
    check("bp_count", popped.size(), exp_seq.size());
    foreach (exp_seq[i]) check($sformatf("bp_ev%0d", i), pop_at(i), exp_seq[i]);

    // Reset mid-stream with two queued events and button 3 held
    popped.delete();
    repeat (6) cyc(4'b0001, 1'b0, 1'b0);
    repeat (7) cyc(4'b0000, 1'b0, 1'b0);
    repeat (2) cyc(4'b1000, 1'b0, 1'b0);
    check("rst_pre_valid", evt_valid, 1'b1);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    model_reset();
    repeat (2) cyc(4'b1000, 1'b0, 1'b0);
    rst = 1'b0;
    popped.delete();
    v_at = -1;
    for (int i = 1; i <= DB + 6; i++) begin
      cyc(4'b1000, 1'b1, 1'b0);
      if (v_at < 0 && evt_valid) v_at = i;
    end
    check("rst_evt_lat", v_at, DB + 3);
    check("rst_count", popped.size(), 1);
    check("rst_ev0", pop_at(0), 4'hC);
    repeat (12) cyc(4'b0000, 1'b1, 1'b0);

    // Randomized traffic with stalls, overflow clears and one reset
    lvl = '0; stall = 0;
    for (int c = 0; c < 4; c++) rem[c] = 1 + ($urandom % 10);
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 4; c++) begin
        if (rem[c] == 0) begin
          lvl[c] = ~lvl[c];
          case ($urandom % 4)
            0:       rem[c] = $urandom_range(1, 3);
            1:       rem[c] = $urandom_range(4, 8);
            2:       rem[c] = $urandom_range(8, 16);
            default: rem[c] = $urandom_range(20, 45);
          endcase
        end
        rem[c]--;
      end
      if (stall > 0) begin
        stall--;
        r = 1'b0;
      end else begin
        if ($urandom % 100 == 0) stall = $urandom_range(20, 80);
        r = ($urandom % 4) != 0;
      end
      if (n == 1500) begin
        rst = 1'b1;
        #1;
        check_all_zero("rand_rst");
        model_reset();
        cyc(lvl, r, 1'b0);
        rst = 1'b0;
      end else begin
        cyc(lvl, r, ($urandom % 64) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
